k2_run_controller: RTL and testbench

Run/load controller for the 8-bit K2 processor core. It owns the 16x8 program memory that feeds the core's `instruction_data`, and fills it over a byte-wide valid/ready load port. It also holds the core in reset while loading, and sequences execution as run, halt, single-step or breakpoint stop through a core clock-enable. A saturating executed-cycle counter is exposed for test and debug.

---
 rtl/k2_ctrl_pkg.sv | 15 +
 rtl/k2_prog_mem.sv | 24 ++
 rtl/k2_run_controller.sv | 129 ++++++++++++
 tb/tb_k2_run_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k2_ctrl_pkg.sv
// rtl/k2_ctrl_pkg.sv - shared types and default widths for the K2 run/load controller
package k2_ctrl_pkg;

  localparam int K2_ADDR_BITS = 4;
  localparam int K2_DATA_BITS = 8;
  localparam int K2_CNT_BITS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } k2_ctrl_state_t;

endpackage

// File: rtl/k2_prog_mem.sv
// rtl/k2_prog_mem.sv - K2 program memory, synchronous write, asynchronous read, no reset
module k2_prog_mem #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_run_controller.sv
// rtl/k2_run_controller.sv - K2 run/load controller: program load, run/halt/step/breakpoint, cycle counter
module k2_run_controller
  import k2_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = K2_ADDR_BITS,
  parameter int DATA_BITS = K2_DATA_BITS,
  parameter int CNT_BITS  = K2_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 load_ready,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 bp_en,
  input  logic [ADDR_BITS-1:0] bp_addr,
  input  logic [ADDR_BITS-1:0] ProgramAddress,
  output logic [DATA_BITS-1:0] instruction_data,
  output logic                 cpu_rst_n,
  output logic                 cpu_en,
  output logic                 loaded,
  output logic                 halted,
  output logic [CNT_BITS-1:0]  cycle_count
);

  localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

  k2_ctrl_state_t       state, state_next;
  logic [ADDR_BITS-1:0] ptr;
  logic                 skip;
  logic                 accept;
  logic                 bp_hit;

  k2_prog_mem #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (ptr),
    .wdata (load_data),
    .raddr (ProgramAddress),
    .rdata (instruction_data)
  );

  // skip masks the breakpoint for the first cycle after a resume so it executes once
  assign bp_hit     = bp_en && (ProgramAddress == bp_addr) && !skip;
  assign load_ready = (state == ST_LOAD);
  assign halted     = (state == ST_HALT);

  always_comb begin
    state_next = state;
    cpu_en     = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_next = ST_LOAD;
        end else if (run_req && loaded) begin
          state_next = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          accept = 1'b1;
          if (ptr == PTR_LAST) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        cpu_en = !(bp_hit || halt_req);
        if (!cpu_en) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        cpu_en = step_req && !run_req;
        if (load_start) begin
          state_next = ST_LOAD;
        end else if (run_req) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cpu_rst_n   <= 1'b0;
      ptr         <= '0;
      loaded      <= 1'b0;
      skip        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_next;
      cpu_rst_n <= (state_next == ST_RUN) || (state_next == ST_HALT);

      // any entry to LOAD restarts the image, so the old program is no longer complete
      if (state != ST_LOAD && state_next == ST_LOAD) begin
        ptr    <= '0;
        loaded <= 1'b0;
      end else if (accept) begin
        ptr <= ptr + 1'b1;
        if (ptr == PTR_LAST) begin
          loaded <= 1'b1;
        end
      end

      if (state == ST_HALT && state_next == ST_RUN) begin
        skip <= 1'b1;
      end else if (state == ST_RUN) begin
        skip <= 1'b0;
      end

      if (state == ST_IDLE && state_next == ST_RUN) begin
        cycle_count <= '0;
      end else if (cpu_en && cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_k2_run_controller.sv
// tb/tb_k2_run_controller.sv - randomized self-checking bench for k2_run_controller against a behavioural model
module tb_k2_run_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_valid, load_ready;
  logic [7:0] load_data;
  logic       run_req, halt_req, step_req, bp_en;
  logic [3:0] bp_addr, ProgramAddress;
  logic [7:0] instruction_data;
  logic       cpu_rst_n, cpu_en, loaded, halted;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  int         m_mode;
  int         m_ptr;
  int         m_count;
  bit         m_loaded, m_skip, m_rst_out;
  logic [7:0] m_mem [16];
  bit         m_valid [16];

  always #5 clk = ~clk;

  k2_run_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .run_req          (run_req),
    .halt_req         (halt_req),
    .step_req         (step_req),
    .bp_en            (bp_en),
    .bp_addr          (bp_addr),
    .ProgramAddress   (ProgramAddress),
    .instruction_data (instruction_data),
    .cpu_rst_n        (cpu_rst_n),
    .cpu_en           (cpu_en),
    .loaded           (loaded),
    .halted           (halted),
    .cycle_count      (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    bp_en = 1'b0; bp_addr = 4'h0;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_count = 0;
    m_loaded = 1'b0; m_skip = 1'b0; m_rst_out = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit model_en();
    bit hit;
    hit = bp_en && (ProgramAddress == bp_addr) && !m_skip;
    if (m_mode == M_RUN)  return !(hit || halt_req);
    if (m_mode == M_HALT) return step_req && !run_req;
    return 1'b0;
  endfunction

  task automatic model_step(input bit en);
    if (en && m_count < 65535) m_count++;
    case (m_mode)
      M_IDLE: begin
        if (load_start) begin
          m_mode = M_LOAD; m_ptr = 0; m_loaded = 1'b0;
        end else if (run_req && m_loaded) begin
          m_mode = M_RUN; m_count = 0;
        end
      end
      M_LOAD: begin
        if (load_valid) begin
          m_mem[m_ptr] = load_data;
          m_valid[m_ptr] = 1'b1;
          if (m_ptr == 15) begin
            m_mode = M_IDLE; m_loaded = 1'b1; m_ptr = 0;
          end else begin
            m_ptr++;
          end
        end
      end
      M_RUN: begin
        m_skip = 1'b0;
        if (!en) m_mode = M_HALT;
      end
      default: begin
        if (load_start) begin
          m_mode = M_LOAD; m_ptr = 0; m_loaded = 1'b0;
        end else if (run_req) begin
          m_mode = M_RUN; m_skip = 1'b1;
        end
      end
    endcase
    m_rst_out = (m_mode == M_RUN) || (m_mode == M_HALT);
  endtask

  // inputs are set at the falling edge; outputs are checked 1ns later, then the model follows the rising edge
  task automatic tick();
    bit en;
    #1;
    en = model_en();
    check("cpu_en",      32'(cpu_en),      32'(en));
    check("load_ready",  32'(load_ready),  32'(m_mode == M_LOAD));
    check("halted",      32'(halted),      32'(m_mode == M_HALT));
    check("loaded",      32'(loaded),      32'(m_loaded));
    check("cpu_rst_n",   32'(cpu_rst_n),   32'(m_rst_out));
    check("cycle_count", 32'(cycle_count), 32'(m_count));
    if (m_valid[ProgramAddress]) check("instr", 32'(instruction_data), 32'(m_mem[ProgramAddress]));
    @(posedge clk);
    model_step(en);
    @(negedge clk);
  endtask

  task automatic load_program(input bit randomize_data);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = randomize_data ? 8'($urandom) : 8'(i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  int base;

  initial begin
    clear_inputs();
    ProgramAddress = 4'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_cpu_rst_n",  32'(cpu_rst_n),   32'd0);
    check("rst_cpu_en",     32'(cpu_en),      32'd0);
    check("rst_load_ready", 32'(load_ready),  32'd0);
    check("rst_loaded",     32'(loaded),      32'd0);
    check("rst_halted",     32'(halted),      32'd0);
    check("rst_count",      32'(cycle_count), 32'd0);
    rst_n = 1'b1;

    // back-to-back load of 0x00..0x0F, then run
    ProgramAddress = 4'd5;
    load_program(1'b0);
    check("loaded_after_16", 32'(loaded), 32'd1);
    check("instr_at_5",      32'(instruction_data), 32'h05);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("cpu_rst_n_rise", 32'(cpu_rst_n), 32'd1);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halted_after_halt", 32'(halted), 32'd1);

    // reload from HALT with load_valid toggling and run_req held during LOAD
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = (i % 2 == 0);
      load_data  = 8'($urandom);
      run_req    = (i != 31);
      tick();
    end
    clear_inputs();
    check("toggle_loaded", 32'(loaded), 32'd1);
    check("toggle_idle",   32'(cpu_rst_n), 32'd0);
    for (int a = 0; a < 16; a++) begin
      ProgramAddress = 4'(a);
      tick();
    end

    // breakpoint at 3
    bp_en = 1'b1; bp_addr = 4'd3; ProgramAddress = 4'd0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int pa = 0; pa < 4; pa++) begin
      ProgramAddress = 4'(pa);
      tick();
    end
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_count",  32'(cycle_count), 32'd3);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    ProgramAddress = 4'd4;
    tick();
    check("bp_resume_count", 32'(cycle_count), 32'd5);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;

    // single steps, then step with run together
    base = int'(cycle_count);
    step_req = 1'b1; tick();
    step_req = 1'b0; tick();
    check("step1", 32'(cycle_count), 32'(base + 1));
    step_req = 1'b1; tick(); tick();
    step_req = 1'b0; tick();
    check("step2", 32'(cycle_count), 32'(base + 3));
    step_req = 1'b1; run_req = 1'b1;
    tick();
    clear_inputs();
    check("step_run_to_run", 32'(halted), 32'd0);
    halt_req = 1'b1; tick();
    halt_req = 1'b0;

    // asynchronous reset mid-LOAD
    load_start = 1'b1; tick();
    load_start = 1'b0; load_valid = 1'b1;
    tick(); tick(); tick();
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_loaded",     32'(loaded),      32'd0);
    check("mid_rst_load_ready", 32'(load_ready),  32'd0);
    check("mid_rst_cpu_rst_n",  32'(cpu_rst_n),   32'd0);
    check("mid_rst_count",      32'(cycle_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    load_program(1'b1);
    for (int i = 0; i < 3000; i++) begin
      load_start     = ($urandom_range(15, 0) == 0);
      load_valid     = ($urandom_range(1, 0) == 1);
      load_data      = 8'($urandom);
      run_req        = ($urandom_range(5, 0) == 0);
      halt_req       = ($urandom_range(7, 0) == 0);
      step_req       = ($urandom_range(3, 0) == 0);
      bp_en          = ($urandom_range(1, 0) == 1);
      bp_addr        = 4'($urandom);
      ProgramAddress = 4'($urandom);
      tick();
    end
    clear_inputs();

    // counter saturation over a long run
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load_program(1'b1);
    run_req = 1'b1; tick();
    run_req = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      ProgramAddress = 4'($urandom);
      tick();
    end
    check("sat_count", 32'(cycle_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
